// File: rtl/sample_recorder_if.sv
// rtl/sample_recorder_if.sv - record-in and playback-out stream handshake bundle
interface sample_recorder_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sample_recorder.sv
// rtl/sample_recorder.sv - records a sample stream into a 2**ADDR_WIDTH RAM and plays it back
module sample_recorder #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_rec,
    input  logic                  start_play,
    input  logic                  loop,
    input  logic                  stop,
    sample_recorder_if.slave      bus,
    output logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, REC, PLAY} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  loop_r;
    logic                  primed;
    logic                  in_ready_r;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic                  wr_hs;
    logic                  rd_hs;
    logic                  rd_last;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign busy          = (state != IDLE);

    // rd_ptr is the index currently held in out_data; rd_addr looks one ahead on a handshake.
    always_comb begin
        wr_hs   = (state == REC) && bus.in_valid && in_ready_r;
        rd_hs   = (state == PLAY) && out_valid_r && bus.out_ready;
        rd_last = ({1'b0, rd_ptr} == (length - (ADDR_WIDTH+1)'(1)));
        rd_addr = rd_ptr;
        if (rd_hs) begin
            rd_addr = rd_last ? '0 : rd_ptr + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_hs && !rst) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            length      <= '0;
            loop_r      <= 1'b0;
            primed      <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rec) begin
                        state      <= REC;
                        wr_ptr     <= '0;
                        in_ready_r <= 1'b1;
                    end else if (start_play && length != '0) begin
                        state       <= PLAY;
                        rd_ptr      <= '0;
                        loop_r      <= loop;
                        primed      <= 1'b0;
                        out_valid_r <= 1'b0;
                    end
                end
                REC: begin
                    if (wr_hs) begin
                        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                    end
                    // A handshake in the same cycle as stop still counts toward length.
                    if (stop || (wr_hs && wr_ptr == '1)) begin
                        state      <= IDLE;
                        in_ready_r <= 1'b0;
                        done       <= 1'b1;
                        length     <= {1'b0, wr_ptr} + (ADDR_WIDTH+1)'(wr_hs);
                    end
                end
                PLAY: begin
                    if (stop || (rd_hs && rd_last && !loop_r)) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        done        <= 1'b1;
                    end else begin
                        // Stalls re-read the same address, so out_data holds steady.
                        rd_ptr     <= rd_addr;
                        out_data_r <= mem[rd_addr];
                        if (!out_valid_r) begin
                            primed      <= 1'b1;
                            out_valid_r <= primed;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sample_recorder.md
Name: sample_recorder

Overview:
- Writer-side counterpart to the sine lookup ROM: records a stream of 8-bit samples into an internal 256x8 RAM, then plays them back.
- Recording uses a valid/ready handshake from the sample source.
- Playback uses a valid/ready handshake to the downstream consumer, for example the DAC/scope path used by the signal generator.
- Supports one-shot and looping playback, with a stop control.

Parameters:
ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH words
DATA_WIDTH, 8, sample width

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
start_rec  input  1  begin recording at address 0 (sampled in IDLE only)
start_play  input  1  begin playback at address 0 (sampled in IDLE only)
loop  input  1  sampled with start_play; 1 = wrap at end of recording
stop  input  1  end current recording/playback
in_valid  input  1  source sample valid
in_data  input  DATA_WIDTH  source sample
in_ready  output  1  recorder accepting samples
out_valid  output  1  playback sample valid
out_data  output  DATA_WIDTH  playback sample
out_ready  input  1  consumer accepts sample
length  output  ADDR_WIDTH+1  number of samples in last recording (0..DEPTH)
busy  output  1  state != IDLE
done  output  1  one-cycle pulse on any REC->IDLE or PLAY->IDLE

Behaviour:
- Reset (rst high at a rising edge):
  - state = IDLE; wr_ptr, rd_ptr, length = 0.
  - in_ready, out_valid, done, busy = 0; out_data = 0.
  - RAM contents are not cleared.
  - Reset mid-operation aborts immediately; done is not pulsed.
- States: IDLE, REC, PLAY. All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- IDLE:
  - start_rec -> REC, wr_ptr = 0.
  - Else start_play with length != 0 -> PLAY, rd_ptr = 0, loop latched.
  - start_play with length == 0 is ignored.
  - start_rec and start_play together: start_rec wins.
  - stop is ignored.
- REC:
  - in_ready = 1 from the first cycle in REC.
  - Handshake in_valid & in_ready writes mem[wr_ptr] = in_data at that edge, then wr_ptr increments.
  - Handshake at wr_ptr == DEPTH-1: length = DEPTH, -> IDLE, done pulse. in_ready is low the next cycle.
  - stop in REC: -> IDLE, done pulse, length = samples written. A handshake in the same cycle as stop is written and counted.
  - start_* is ignored in REC.
- PLAY:
  - Synchronous RAM read with 1-cycle latency.
  - First out_valid asserts two rising edges after the edge that sampled start_play.
  - Read address is look-ahead: rd_ptr+1 when a handshake occurs, else rd_ptr. This sustains 1 sample/cycle with out_ready held high.
  - While out_valid & !out_ready: out_data and out_valid hold stable.
  - Handshake on index length-1:
    - loop = 0: -> IDLE, out_valid low next cycle, done pulse.
    - loop = 1: the next sample is index 0, with no bubble.
  - stop in PLAY: -> IDLE next edge, out_valid = 0, done pulse. A handshake in the same cycle counts as delivered.
  - length is unchanged by playback.
- Widths and counters:
  - Pointers are ADDR_WIDTH bits.
  - length is ADDR_WIDTH+1 bits so DEPTH is representable.
  - The write counter never wraps: recording ends at DEPTH.
- done is high for exactly one cycle per completed or stopped operation and is low in all other cycles.

Test Plan:
1. Reset: assert rst 2 cycles mid-PLAY -> next cycle all outputs 0, busy 0, length 0, no done pulse.
2. Record/play: start_rec; send 0x11, 0x22, 0x33, 0x44; pulse stop -> length = 4, single done pulse.
   Then start_play with loop = 0, out_ready = 1 -> out_data 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles, then out_valid 0 and done pulse.
3. Full buffer: record 256 samples of value i -> after the 256th handshake length = 256, in_ready 0 next cycle, done pulse. Playback returns 0x00..0xFF in order.
4. Backpressure on a recording of 0x0A, 0x0B, 0x0C:
   - Toggle out_ready 1,0,0,1,1 -> out_data is held at 0x0B while stalled.
   - Each sample is delivered exactly once, in order.
   - in_valid gaps during recording insert no samples.
5. Loop: length 3 (0x0A, 0x0B, 0x0C), loop = 1, out_ready = 1 -> 0x0A, 0x0B, 0x0C, 0x0A, 0x0B, ... with no bubble. stop -> out_valid 0 next cycle, done pulse.
6. Corner cases:
   - start_play with length 0 -> stays IDLE.
   - start_rec and start_play in the same cycle -> REC.
   - stop coincident with an in handshake -> that sample is counted in length.
